// File: rtl/bus_data_in.sv
// Read-data receive path for the B bus: captures read data, extracts bytes or
// rotates unaligned words, and feeds opcode fetches into a D/E instruction pipeline.
module bus_data_in #(
  parameter logic [31:0] RESET_INSTR = 32'hE1A00000,
  parameter logic [31:0] RESET_DATA  = 32'h00000000
) (
  input  logic        phi2_clk,
  input  logic        nreset,
  input  logic [31:0] d_pad,
  input  logic        mem_valid,
  input  logic        n_rw,
  input  logic        n_opc,
  input  logic        bw,
  input  logic [1:0]  addr_lo,
  input  logic        abort,
  input  logic        flush,
  input  logic        advance,
  output logic [31:0] data_in,
  output logic        data_in_valid,
  output logic        data_abort,
  output logic [31:0] decode_instr,
  output logic        decode_valid,
  output logic [31:0] instr_reg,
  output logic        instr_valid,
  output logic        instr_abort,
  output logic        fetch_ready,
  output logic        overrun
);

  logic        is_fetch;
  logic        is_dread;
  logic        fetch_take;
  logic        decode_abort;
  logic [4:0]  shamt;
  logic [63:0] dbl;
  logic [31:0] rot_word;
  logic [31:0] ext_data;

  assign is_fetch    = mem_valid & ~n_rw & ~n_opc;
  assign is_dread    = mem_valid & ~n_rw & n_opc;
  assign fetch_ready = ~decode_valid | advance | flush;
  assign fetch_take  = is_fetch & fetch_ready;

  // Rotate by shifting a doubled copy; byte mode keeps only the low lane.
  assign shamt    = {addr_lo, 3'b000};
  assign dbl      = {d_pad, d_pad} >> shamt;
  assign rot_word = dbl[31:0];

  always_comb begin
    ext_data = rot_word;
    if (!bw) begin
      ext_data = {24'h000000, rot_word[7:0]};
    end
  end

  always_ff @(posedge phi2_clk) begin
    if (!nreset) begin
      data_in       <= RESET_DATA;
      data_in_valid <= 1'b0;
      data_abort    <= 1'b0;
    end else begin
      data_in_valid <= is_dread & ~abort;
      data_abort    <= is_dread & abort;
      if (is_dread && !abort) begin
        data_in <= ext_data;
      end
    end
  end

  // D abort tag is kept at 0 whenever D is invalid, so E can copy it unconditionally.
  always_ff @(posedge phi2_clk) begin
    if (!nreset) begin
      decode_instr <= RESET_INSTR;
      decode_valid <= 1'b0;
      decode_abort <= 1'b0;
      instr_reg    <= RESET_INSTR;
      instr_valid  <= 1'b0;
      instr_abort  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (is_fetch && !fetch_ready) begin
        overrun <= 1'b1;
      end
      if (flush) begin
        instr_valid <= 1'b0;
        instr_abort <= 1'b0;
      end else if (advance) begin
        instr_valid <= decode_valid;
        instr_abort <= decode_abort;
        if (decode_valid) begin
          instr_reg <= decode_instr;
        end
      end
      if (fetch_take) begin
        decode_instr <= d_pad;
        decode_valid <= 1'b1;
        decode_abort <= abort;
      end else if (flush || advance) begin
        decode_valid <= 1'b0;
        decode_abort <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_data_in.sv
// Directed bench for bus_data_in: a per-cycle behavioural model checked against
// every output on each falling edge, plus hand-computed literal expectations.
module tb_bus_data_in;

  logic        phi2_clk;
  logic        nreset;
  logic [31:0] d_pad;
  logic        mem_valid, n_rw, n_opc, bw, abort, flush, advance;
  logic [1:0]  addr_lo;
  logic [31:0] data_in, decode_instr, instr_reg;
  logic        data_in_valid, data_abort, decode_valid, instr_valid, instr_abort;
  logic        fetch_ready, overrun;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  bus_data_in #(.RESET_INSTR(32'hE1A00000), .RESET_DATA(32'h00000000)) dut (
    .phi2_clk(phi2_clk), .nreset(nreset), .d_pad(d_pad), .mem_valid(mem_valid),
    .n_rw(n_rw), .n_opc(n_opc), .bw(bw), .addr_lo(addr_lo), .abort(abort),
    .flush(flush), .advance(advance), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_abort(data_abort),
    .decode_instr(decode_instr), .decode_valid(decode_valid),
    .instr_reg(instr_reg), .instr_valid(instr_valid), .instr_abort(instr_abort),
    .fetch_ready(fetch_ready), .overrun(overrun)
  );

  initial phi2_clk = 1'b0;
  always #5 phi2_clk = ~phi2_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pipeline slots as plain records, updated from the rules.
  logic [31:0] m_data, m_dinstr, m_ireg;
  logic        m_dvalid_out, m_dabort_out, m_dv, m_da, m_ev, m_ea, m_ovr;

  function automatic logic [31:0] model_extract(input logic [31:0] w, input logic [1:0] a,
                                                input logic word);
    logic [7:0] b [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    if (!word) return {24'h0, b[a]};
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[(i + int'(a)) % 4];
    return r;
  endfunction

  always @(posedge phi2_clk) begin
    logic f, dr, acc;
    if (!nreset) begin
      m_data = 32'h0; m_dvalid_out = 0; m_dabort_out = 0;
      m_dinstr = 32'hE1A00000; m_ireg = 32'hE1A00000;
      m_dv = 0; m_da = 0; m_ev = 0; m_ea = 0; m_ovr = 0;
    end else begin
      f  = mem_valid && !n_rw && !n_opc;
      dr = mem_valid && !n_rw && n_opc;
      m_dvalid_out = 0;
      m_dabort_out = 0;
      if (dr) begin
        if (abort) m_dabort_out = 1;
        else begin
          m_dvalid_out = 1;
          m_data = model_extract(d_pad, addr_lo, bw);
        end
      end
      acc = f && (!m_dv || advance || flush);
      if (f && !acc) m_ovr = 1;
      if (flush) begin
        m_ev = 0; m_ea = 0; m_dv = 0; m_da = 0;
      end else if (advance) begin
        if (m_dv) begin
          m_ev = 1; m_ea = m_da; m_ireg = m_dinstr;
        end else begin
          m_ev = 0; m_ea = 0;
        end
        m_dv = 0; m_da = 0;
      end
      if (acc) begin
        m_dv = 1; m_dinstr = d_pad; m_da = abort;
      end
    end
  end

  always @(negedge phi2_clk) begin
    if (chk_en) begin
      chk("m_data_in", data_in, m_data);
      chk("m_data_in_valid", {31'h0, data_in_valid}, {31'h0, m_dvalid_out});
      chk("m_data_abort", {31'h0, data_abort}, {31'h0, m_dabort_out});
      chk("m_decode_valid", {31'h0, decode_valid}, {31'h0, m_dv});
      chk("m_decode_instr", decode_instr, m_dinstr);
      chk("m_instr_valid", {31'h0, instr_valid}, {31'h0, m_ev});
      chk("m_instr_reg", instr_reg, m_ireg);
      chk("m_instr_abort", {31'h0, instr_abort}, {31'h0, m_ea});
      chk("m_fetch_ready", {31'h0, fetch_ready},
          {31'h0, (!m_dv || advance || flush)});
      chk("m_overrun", {31'h0, overrun}, {31'h0, m_ovr});
    end
  end

  // kind: 0 idle, 1 fetch, 2 data read, 3 write
  task automatic set_in(input int kind, input logic [31:0] d, input logic b,
                        input logic [1:0] a, input logic ab, input logic fl,
                        input logic adv);
    mem_valid = (kind != 0);
    n_rw      = (kind == 3 || kind == 0);
    n_opc     = (kind != 1);
    d_pad = d; bw = b; addr_lo = a; abort = ab; flush = fl; advance = adv;
  endtask

  task automatic tick;
    @(posedge phi2_clk);
    #1;
  endtask

  task automatic step(input int kind, input logic [31:0] d, input logic b,
                      input logic [1:0] a, input logic ab, input logic fl,
                      input logic adv);
    set_in(kind, d, b, a, ab, fl, adv);
    tick();
  endtask

  logic [31:0] lane_exp [4];

  initial begin
    lane_exp[0] = 32'h44; lane_exp[1] = 32'h33; lane_exp[2] = 32'h22; lane_exp[3] = 32'h11;
    nreset = 1'b0;
    step(1, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    chk("rst_instr_reg", instr_reg, 32'hE1A00000);
    chk("rst_decode_instr", decode_instr, 32'hE1A00000);
    chk("rst_data_in", data_in, 32'h0);
    chk("rst_valids", {data_in_valid, data_abort, decode_valid, instr_valid, instr_abort, overrun}, 0);
    chk_en = 1'b1;
    nreset = 1'b1;

    step(2, 32'h11223344, 0, 2'b10, 0, 0, 0);
    chk("byte_lane2", data_in, 32'h00000022);
    chk("byte_valid", {31'h0, data_in_valid}, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("valid_pulse_end", {31'h0, data_in_valid}, 0);
    step(2, 32'h11223344, 1, 2'b01, 0, 0, 0);
    chk("rot8", data_in, 32'h44112233);
    step(2, 32'h11223344, 1, 2'b00, 0, 0, 0);
    chk("rot0", data_in, 32'h11223344);
    step(2, 32'h11223344, 1, 2'b10, 0, 0, 0);
    chk("rot16", data_in, 32'h33441122);
    step(2, 32'h11223344, 1, 2'b11, 0, 0, 0);
    chk("rot24", data_in, 32'h22334411);
    for (int i = 0; i < 4; i++) begin
      step(2, 32'h11223344, 0, 2'(i), 0, 0, 0);
      chk("byte_lane", data_in, lane_exp[i]);
    end
    step(2, 32'hFFFFFFFF, 1, 0, 1, 0, 0);
    chk("abort_hold", data_in, 32'h11);
    chk("abort_pulse", {30'h0, data_abort, data_in_valid}, 32'h2);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("abort_pulse_end", {31'h0, data_abort}, 0);
    step(3, 32'hCAFEF00D, 1, 0, 0, 0, 0);
    chk("write_ignored", {data_in_valid, decode_valid}, 0);

    step(1, 32'hE3A00001, 1, 0, 0, 0, 0);
    chk("fetch_to_d", {decode_valid, instr_valid}, 32'h2);
    chk("fetch_d_instr", decode_instr, 32'hE3A00001);
    step(0, 0, 1, 0, 0, 0, 1);
    chk("adv_ireg", instr_reg, 32'hE3A00001);
    chk("adv_valids", {decode_valid, instr_valid}, 32'h1);

    step(1, 32'hE0811002, 1, 0, 0, 0, 0);
    set_in(1, 32'hE2800001, 1, 0, 0, 0, 0);
    #1;
    chk("fetch_ready_low", {31'h0, fetch_ready}, 0);
    tick();
    chk("ovr_d_kept", decode_instr, 32'hE0811002);
    chk("ovr_set", {31'h0, overrun}, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    chk("ovr_adv_ireg", instr_reg, 32'hE0811002);
    chk("ovr_sticky", {31'h0, overrun}, 1);

    step(1, 32'hE1A01002, 1, 0, 0, 0, 0);
    chk("both_valid", {decode_valid, instr_valid}, 32'h3);
    step(1, 32'hEA000000, 1, 0, 1, 1, 1);
    chk("flush_e", {31'h0, instr_valid}, 0);
    chk("flush_d", {decode_valid, instr_abort}, 32'h2);
    chk("flush_d_instr", decode_instr, 32'hEA000000);
    chk("flush_ireg_kept", instr_reg, 32'hE0811002);
    step(0, 0, 1, 0, 0, 0, 1);
    chk("tag_travel", {instr_valid, instr_abort, decode_valid}, 32'h6);
    chk("tag_ireg", instr_reg, 32'hEA000000);
    step(0, 0, 1, 0, 0, 0, 1);
    chk("bubble", {instr_valid, instr_abort}, 0);
    chk("bubble_ireg", instr_reg, 32'hEA000000);

    step(1, 32'h11111111, 1, 0, 0, 0, 0);
    step(1, 32'h22222222, 1, 0, 0, 0, 1);
    chk("adv_fetch_e", instr_reg, 32'h11111111);
    chk("adv_fetch_d", decode_instr, 32'h22222222);
    chk("adv_fetch_v", {decode_valid, instr_valid}, 32'h3);
    step(0, 32'h33333333, 1, 0, 0, 0, 0);
    chk("no_mv_ignored", decode_instr, 32'h22222222);

    nreset = 1'b0;
    step(2, 32'h55667788, 0, 0, 0, 0, 0);
    chk("mid_rst_data", data_in, 32'h0);
    chk("mid_rst_flags", {data_in_valid, decode_valid, instr_valid, overrun}, 0);
    chk("mid_rst_ireg", instr_reg, 32'hE1A00000);
    nreset = 1'b1;
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_data_in.md
Name: bus_data_in

Overview:
- Receive-side counterpart of the B-bus data-out path.
- Captures the 32-bit data pins on completed memory reads.
- Opcode fetches go into a two-stage instruction pipeline: decode stage (D), then execute stage (E, drives the instruction register).
- Data reads are byte-extracted or rotated and presented as DATA IN to the B bus.

Parameters:
RESET_INSTR, 32'hE1A00000, value of instr_reg and decode_instr after reset (MOV r0,r0 no-op)
RESET_DATA, 32'h00000000, value of data_in after reset

Ports:
phi2_clk  input  1  sole clock; all state updates on rising edge
nreset  input  1  synchronous active-low reset
d_pad  input  32  data pins (read data)
mem_valid  input  1  memory cycle completes this clock (nWAIT released)
n_rw  input  1  0 = read cycle, 1 = write cycle (write cycles ignored)
n_opc  input  1  0 = opcode fetch, 1 = data access
bw  input  1  1 = word access, 0 = byte access
addr_lo  input  2  address bits [1:0] of the current cycle
abort  input  1  memory abort for the completing cycle
flush  input  1  pipeline refill (branch / exception)
advance  input  1  core retires E; D moves to E
data_in  output  32  last extracted read data
data_in_valid  output  1  one-cycle pulse when data_in is updated
data_abort  output  1  one-cycle pulse: data read aborted
decode_instr  output  32  D-stage instruction
decode_valid  output  1  D-stage holds a valid instruction
instr_reg  output  32  E-stage instruction
instr_valid  output  1  E-stage holds a valid instruction
instr_abort  output  1  E-stage instruction carries a prefetch-abort tag
fetch_ready  output  1  a fetch completing this clock will be accepted
overrun  output  1  sticky: a fetch arrived while it could not be accepted

Behaviour:
- Reset (nreset=0 at edge):
  - instr_reg and decode_instr = RESET_INSTR; data_in = RESET_DATA.
  - All valids, abort tags, data_in_valid, data_abort and overrun = 0.
  - Reset mid-cycle discards any in-flight capture.
- Cycle classes, each sampled only when mem_valid=1:
  - fetch: n_rw=0, n_opc=0
  - data read: n_rw=0, n_opc=1
  - write: n_rw=1, no effect
- Data read extraction:
  - bw=0: data_in = zero-extended byte lane addr_lo, i.e. d_pad[8*addr_lo+7 : 8*addr_lo].
  - bw=1: data_in = d_pad rotated right by 8*addr_lo (unaligned word rotate; addr_lo=0 gives unchanged).
  - Registered; data_in_valid high exactly the clock after capture; latency 1.
  - abort=1 on a data read: data_in holds its old value, data_abort pulses 1 clock, data_in_valid stays 0.
- Pipeline, priority flush > advance > hold:
  - flush=1: D and E valid cleared, tags cleared. A fetch completing the same clock is accepted into D (first target fetch). advance is ignored.
  - advance=1 (no flush): E <= D, i.e. instr_reg, instr_valid and instr_abort are copied from D. If D is invalid, E becomes invalid (bubble); instr_reg keeps its old value. D is then loaded by a simultaneous fetch, otherwise it becomes invalid.
  - Neither: E holds. D is loaded by a fetch if D is invalid.
- Fetch path:
  - A fetch always enters D, never E directly, so minimum fetch-to-E latency is 2 clocks.
  - The abort value is stored as the D tag and travels with the instruction.
- fetch_ready = ~decode_valid | advance | flush (combinational).
- Fetch with fetch_ready=0: instruction dropped, D/E unchanged, overrun set. overrun is cleared only by reset.
- Data reads and fetches never coincide in one cycle; a write with mem_valid changes nothing.
- decode_instr and instr_reg keep their last value when invalid; consumers gate on the valid outputs.

Test Plan:
- Reset with d_pad=32'hDEADBEEF, mem_valid=1 → next clock instr_reg=decode_instr=32'hE1A00000, data_in=0, all valids/overrun 0.
- Byte read d_pad=32'h11223344, bw=0, addr_lo=2'b10 → next clock data_in=32'h00000022, data_in_valid=1 for one clock.
- Word read d_pad=32'h11223344, bw=1, addr_lo=2'b01 → data_in=32'h44112233; with addr_lo=0 → 32'h11223344.
- Fetch 32'hE3A00001 with advance=0, then advance=1 → decode_valid=1 after clock 1; instr_reg=32'hE3A00001, instr_valid=1, decode_valid=0 after clock 2.
- D valid, advance=0, fetch 32'hE2800001 arrives → fetch_ready=0, D unchanged, overrun=1 and remains 1 after later advances.
- D and E valid, flush=1 with simultaneous fetch 32'hEA000000, abort=1 → instr_valid=0; decode_valid=1 with decode_instr=32'hEA000000; next advance gives instr_abort=1.
